// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter with hold limit.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 4;
  localparam int MAX_N        = 8;

  function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [2:0] idx);
    return MAX_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_hold_if.sv
// Request/grant bundle between the requesting agents (master) and the arbiter (slave).
interface rr_arbiter_hold_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic [IDW+1:0] hold_cnt;

  modport master (output req, input gnt, gnt_id, busy, hold_cnt);
  modport slave  (input req, output gnt, gnt_id, busy, hold_cnt);
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first candidate at or after start, with wrap-around.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  input  logic [N-1:0]   excl,
  output logic           found,
  output logic [IDW-1:0] winner
);

  logic [N-1:0]   cand;
  logic [IDW-1:0] idx;

  assign cand = req & ~excl;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(start) + k) % N);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with registered sticky grants and a hold limit
// that forces handoff after MAX_HOLD cycles when someone else is waiting.
module rr_arbiter_hold
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDW      = 2
) (
  input  logic              clock,
  input  logic              reset,
  rr_arbiter_hold_if.slave  bus
);

  localparam logic [IDW+1:0] HOLD_LIM = (IDW+2)'(MAX_HOLD - 1);

  arb_state_e     state, state_n;
  logic [IDW-1:0] last, last_n;
  logic [N-1:0]   gnt, gnt_n;
  logic [IDW-1:0] gnt_id, gnt_id_n;
  logic [IDW+1:0] hold_cnt, hold_n;

  logic [IDW-1:0] start;
  logic [N-1:0]   excl;
  logic           found;
  logic [IDW-1:0] winner;

  // While owning, last always equals the owner, so one search from last+1
  // that excludes the owner serves both release and preemption.
  assign start = (last == IDW'(N - 1)) ? '0 : last + IDW'(1);
  assign excl  = (state == OWN) ? N'(idx_to_onehot(3'(last))) : '0;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (bus.req),
    .start  (start),
    .excl   (excl),
    .found  (found),
    .winner (winner)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      last     <= IDW'(N - 1);
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n  = state;
    last_n   = last;
    gnt_n    = gnt;
    gnt_id_n = gnt_id;
    hold_n   = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_n  = OWN;
          last_n   = winner;
          gnt_n    = N'(idx_to_onehot(3'(winner)));
          gnt_id_n = winner;
          hold_n   = '0;
        end
      end
      OWN: begin
        // Release takes precedence over preemption on the same edge.
        if (!bus.req[last]) begin
          if (found) begin
            last_n   = winner;
            gnt_n    = N'(idx_to_onehot(3'(winner)));
            gnt_id_n = winner;
            hold_n   = '0;
          end else begin
            state_n  = IDLE;
            gnt_n    = '0;
            gnt_id_n = '0;
            hold_n   = '0;
          end
        end else if (hold_cnt == HOLD_LIM && found) begin
          last_n   = winner;
          gnt_n    = N'(idx_to_onehot(3'(winner)));
          gnt_id_n = winner;
          hold_n   = '0;
        end else if (hold_cnt != HOLD_LIM) begin
          hold_n = hold_cnt + (IDW+2)'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.gnt      = gnt;
  assign bus.gnt_id   = gnt_id;
  assign bus.busy     = |gnt;
  assign bus.hold_cnt = hold_cnt;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: a MAX_HOLD=4 and a MAX_HOLD=1 instance share one request vector.
module tb_rr_arbiter_hold;

  logic       clock;
  logic       reset;
  logic [3:0] req;

  int vectors     = 0;
  int miscompares = 0;

  int m_owner [2];
  int m_last  [2];
  int m_held  [2];
  int maxh    [2] = '{4, 1};

  rr_arbiter_hold_if #(.N(4), .IDW(2)) bus4 ();
  rr_arbiter_hold_if #(.N(4), .IDW(2)) bus1 ();

  assign bus4.req = req;
  assign bus1.req = req;

  rr_arbiter_hold #(.N(4), .MAX_HOLD(4), .IDW(2)) u_dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  rr_arbiter_hold #(.N(4), .MAX_HOLD(1), .IDW(2)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or after start (wrapping), skipping excl; -1 if none.
  function automatic int rrSearch(input logic [3:0] r, input int start, input int excl);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (start + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic modelStep(input int d);
    int w;
    if (reset) begin
      m_owner[d] = -1;
      m_last[d]  = 3;
      m_held[d]  = 0;
    end else if (m_owner[d] < 0) begin
      w = rrSearch(req, m_last[d] + 1, -1);
      if (w >= 0) begin
        m_owner[d] = w;
        m_last[d]  = w;
        m_held[d]  = 1;
      end
    end else if (!req[m_owner[d]]) begin
      w = rrSearch(req, m_owner[d] + 1, m_owner[d]);
      if (w >= 0) begin
        m_owner[d] = w;
        m_last[d]  = w;
        m_held[d]  = 1;
      end else begin
        m_owner[d] = -1;
        m_held[d]  = 0;
      end
    end else begin
      w = rrSearch(req, m_owner[d] + 1, m_owner[d]);
      if (m_held[d] >= maxh[d] && w >= 0) begin
        m_owner[d] = w;
        m_last[d]  = w;
        m_held[d]  = 1;
      end else begin
        m_held[d] = m_held[d] + 1;
      end
    end
  endtask

  task automatic cmpDut(input int d, input logic [3:0] g, input logic [1:0] id,
                        input logic b, input logic [3:0] hc);
    logic [3:0] eg;
    int         eh;
    int         eid;
    eg  = (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
    eid = (m_owner[d] < 0) ? 0 : m_owner[d];
    eh  = (m_owner[d] < 0) ? 0 : ((m_held[d] < maxh[d]) ? m_held[d] - 1 : maxh[d] - 1);
    checkOutput($sformatf("dut%0d_gnt", d), 8'(g), 8'(eg));
    checkOutput($sformatf("dut%0d_gnt_id", d), 8'(id), 8'(eid));
    checkOutput($sformatf("dut%0d_busy", d), 8'(b), 8'(m_owner[d] >= 0));
    checkOutput($sformatf("dut%0d_hold_cnt", d), 8'(hc), 8'(eh));
    checkOutput($sformatf("dut%0d_onehot", d), 8'($onehot0(g)), 8'd1);
  endtask

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) modelStep(d);
  end

  always @(posedge clock) begin
    #1;
    cmpDut(0, bus4.gnt, bus4.gnt_id, bus4.busy, bus4.hold_cnt);
    cmpDut(1, bus1.gnt, bus1.gnt_id, bus1.busy, bus1.hold_cnt);
  end

  // Inputs change on the falling edge; one rising edge is consumed per call.
  task automatic applyStimulus(input logic [3:0] r, input logic rs);
    req   = r;
    reset = rs;
    @(negedge clock);
  endtask

  initial begin
    logic [3:0] r;
    req   = 4'b0000;
    reset = 1'b1;
    @(negedge clock);

    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput("reset_gnt", 8'(bus4.gnt), 8'h00);
      checkOutput("reset_busy", 8'(bus4.busy), 8'h00);
    end

    applyStimulus(4'b1111, 1'b0);
    checkOutput("first_gnt", 8'(bus4.gnt), 8'h01);
    checkOutput("first_gnt_id", 8'(bus4.gnt_id), 8'h00);
    for (int k = 1; k < 16; k++) begin
      applyStimulus(4'b1111, 1'b0);
      checkOutput($sformatf("contend_gnt_%0d", k), 8'(bus4.gnt), 8'(4'b0001 << (k / 4)));
    end
    applyStimulus(4'b1111, 1'b0);
    checkOutput("contend_wrap", 8'(bus4.gnt), 8'h01);

    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_pre", 8'(bus4.gnt), 8'h00);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b0100, 1'b0);
      checkOutput($sformatf("single_gnt_%0d", k), 8'(bus4.gnt), 8'h04);
      checkOutput($sformatf("single_hold_%0d", k), 8'(bus4.hold_cnt), 8'((k < 3) ? k : 3));
    end
    applyStimulus(4'b0000, 1'b0);
    checkOutput("single_release", 8'(bus4.gnt), 8'h00);

    applyStimulus(4'b0010, 1'b0);
    checkOutput("handoff_owner", 8'(bus4.gnt), 8'h02);
    applyStimulus(4'b1001, 1'b0);
    checkOutput("handoff_gnt", 8'(bus4.gnt), 8'h08);
    checkOutput("handoff_busy", 8'(bus4.busy), 8'h01);

    applyStimulus(4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(4'b0100, 1'b0);
    checkOutput("midgrant_gnt", 8'(bus4.gnt), 8'h04);
    checkOutput("midgrant_hold", 8'(bus4.hold_cnt), 8'h02);
    applyStimulus(4'b1100, 1'b1);
    checkOutput("midreset_gnt", 8'(bus4.gnt), 8'h00);
    checkOutput("midreset_hold", 8'(bus4.hold_cnt), 8'h00);
    applyStimulus(4'b1100, 1'b0);
    checkOutput("postreset_gnt", 8'(bus4.gnt), 8'h04);

    applyStimulus(4'b0000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0011, 1'b0);
      checkOutput($sformatf("hold1_gnt_%0d", k), 8'(bus1.gnt), 8'((k % 2 == 1) ? 4'b0010 : 4'b0001));
    end

    r = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
      applyStimulus(r, $urandom_range(0, 59) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
